// File: rtl/ocx_leaf_fifo_pkg.sv
// Shared constants for the leaf regfile-backed FIFO controller.
package ocx_leaf_fifo_pkg;

  localparam int ADDR_WIDTH_DFLT = 4;
  localparam int PTR_W           = ADDR_WIDTH_DFLT + 1;
  localparam int SKID_DEPTH      = 2;

  typedef logic [1:0] skid_occ_t;

  // Pointer width carries one extra wrap bit above the regfile address.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ocx_leaf_fifo_ctl_chk.sv
// Simulation-only invariant: skid entries plus in-flight read never exceed two.
module ocx_leaf_fifo_ctl_chk (
  input logic       clk,
  input logic       reset,
  input logic [1:0] occ,
  input logic       infl
);

  a_no_skid_overflow: assert property (
    @(posedge clk) disable iff (reset) ({1'b0, occ} + {2'b00, infl} <= 3'd2)
  );

endmodule

// File: rtl/ocx_leaf_skid_buf2.sv
// Two-entry circular output buffer that absorbs the regfile read latency.
module ocx_leaf_skid_buf2
  import ocx_leaf_fifo_pkg::*;
#(
  parameter int WIDTH = 576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output skid_occ_t        occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_head;
  logic             r_tail;
  skid_occ_t        r_occ;

  // Head/tail/occupancy bookkeeping; capture and pop together leave occ unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (capture) begin
        r_tail <= ~r_tail;
      end
      if (pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, capture} - {1'b0, pop};
    end
  end

  // Data storage needs no reset: the parent masks the head while in reset.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      r_mem[r_tail] <= cap_data;
    end
  end

  assign occ       = r_occ;
  assign head_data = r_mem[r_head];

endmodule

// File: rtl/ocx_leaf_regfile_fifo_ctl.sv
// Valid/ready FIFO built on an external two-port regfile with one-cycle
// registered read, using a 2-entry skid buffer to keep full throughput.
module ocx_leaf_regfile_fifo_ctl
  import ocx_leaf_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 576,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]      rf_wr_data,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  output logic                  rf_rd_rst_n,
  input  logic [WIDTH-1:0]      rf_rd_data,
  output logic [ADDR_WIDTH+1:0] fill_level
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int FW = ADDR_WIDTH + 2;

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_infl;
  logic [PW-1:0]    w_rf_cnt;
  skid_occ_t        w_occ;
  logic [WIDTH-1:0] w_head_data;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;

  assign w_rf_cnt    = r_wptr - r_rptr;
  assign w_in_ready  = !reset && (w_rf_cnt != PW'(DEPTH));
  assign w_push      = in_valid && w_in_ready;
  assign w_out_valid = !reset && (w_occ != 2'd0);
  assign w_pop       = w_out_valid && out_ready;
  // occ + infl - pop < 2, rearranged so nothing underflows.
  assign w_issue     = !reset && (w_rf_cnt != '0) &&
                       (({1'b0, w_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));

  // Write/read pointers and the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_infl <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_issue) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_infl <= w_issue;
    end
  end

  ocx_leaf_skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .capture   (r_infl),
    .cap_data  (rf_rd_data),
    .pop       (w_pop),
    .occ       (w_occ),
    .head_data (w_head_data)
  );

  ocx_leaf_fifo_ctl_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .occ   (w_occ),
    .infl  (r_infl)
  );

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = reset ? '0 : w_head_data;
  assign rf_wr_en    = w_push;
  assign rf_wr_addr  = r_wptr[ADDR_WIDTH-1:0];
  assign rf_wr_data  = in_data;
  assign rf_rd_en    = w_issue;
  assign rf_rd_addr  = r_rptr[ADDR_WIDTH-1:0];
  assign rf_rd_rst_n = ~reset;
  assign fill_level  = reset ? '0 : (FW'(w_rf_cnt) + FW'(r_infl) + FW'(w_occ));

endmodule
